// File: rtl/cam_defs_pkg.sv
// Camera-wide definitions: exposure FSM states and default exposure limits.
// Also used by the frame sequencer, so keep the constants in one place.
package cam_defs_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StExpose = 2'd1,
        StDone   = 2'd2
    } cam_state_e;

    localparam int unsigned CAM_EXP_W       = 5;
    localparam int unsigned CAM_EXP_MIN     = 2;
    localparam int unsigned CAM_EXP_MAX     = 30;
    localparam int unsigned CAM_EXP_DEFAULT = 10;
    localparam int unsigned CAM_TICK_DIV    = 1000;

    // Counter width for a modulus of n, never less than one bit.
    function automatic int unsigned cnt_width(int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rise_edge_detect.sv
// One-cycle pulse on the rising edge of an already-synchronised level input.
module rise_edge_detect (
    input  logic Clk,
    input  logic Reset,
    input  logic level,
    output logic pulse
);

    logic prev_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level;
        end
    end

    assign pulse = level & ~prev_q;

endmodule

// File: rtl/exposure_timer_ctrl.sv
// Exposure setting register with button adjustment, and the exposure window timer
// that drives Expose for Exp_value * TICK_DIV cycles followed by a one-cycle Done.
module exposure_timer_ctrl
    import cam_defs_pkg::*;
#(
    parameter int unsigned EXP_W       = CAM_EXP_W,
    parameter int unsigned EXP_MIN     = CAM_EXP_MIN,
    parameter int unsigned EXP_MAX     = CAM_EXP_MAX,
    parameter int unsigned EXP_DEFAULT = CAM_EXP_DEFAULT,
    parameter int unsigned TICK_DIV    = CAM_TICK_DIV
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Exp_increase,
    input  logic             Exp_decrease,
    input  logic             Start,
    output logic [EXP_W-1:0] Exp_value,
    output logic             Expose,
    output logic             Busy,
    output logic             Done
);

    localparam int unsigned PRE_W = cnt_width(TICK_DIV);

    if (!(EXP_MIN >= 1 && EXP_MIN <= EXP_DEFAULT && EXP_DEFAULT <= EXP_MAX &&
          EXP_MAX <= (2 ** EXP_W) - 1 && TICK_DIV >= 1)) begin : g_bad_params
        $error("exposure_timer_ctrl: inconsistent exposure parameters");
    end

    cam_state_e       state_q, state_d;
    logic [PRE_W-1:0] pre_q;
    logic [EXP_W-1:0] units_q;
    logic [EXP_W-1:0] exp_q;
    logic             inc_req, dec_req;
    logic             tick_wrap, last_tick;

    rise_edge_detect u_inc_edge (
        .Clk   (Clk),
        .Reset (Reset),
        .level (Exp_increase),
        .pulse (inc_req)
    );

    rise_edge_detect u_dec_edge (
        .Clk   (Clk),
        .Reset (Reset),
        .level (Exp_decrease),
        .pulse (dec_req)
    );

    assign tick_wrap = (pre_q == PRE_W'(TICK_DIV - 1));
    assign last_tick = tick_wrap && (units_q == EXP_W'(1));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (Start) state_d = StExpose;
            StExpose: if (last_tick) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        Expose    = (state_q == StExpose);
        Busy      = (state_q != StIdle);
        Done      = (state_q == StDone);
        Exp_value = exp_q;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pre_q   <= '0;
            units_q <= '0;
        end else if (state_q == StIdle && Start) begin
            // Latch the pre-adjust value; an adjust in this cycle affects only exp_q.
            pre_q   <= '0;
            units_q <= exp_q;
        end else if (state_q == StExpose) begin
            if (tick_wrap) begin
                pre_q   <= '0;
                units_q <= units_q - EXP_W'(1);
            end else begin
                pre_q <= pre_q + PRE_W'(1);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            exp_q <= EXP_W'(EXP_DEFAULT);
        end else if (state_q == StIdle) begin
            if (inc_req && !dec_req && exp_q < EXP_W'(EXP_MAX)) begin
                exp_q <= exp_q + EXP_W'(1);
            end else if (dec_req && !inc_req && exp_q > EXP_W'(EXP_MIN)) begin
                exp_q <= exp_q - EXP_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_exposure_timer_ctrl.sv
// Self-checking bench for exposure_timer_ctrl with TICK_DIV=4: table vectors,
// directed corner sequences and a randomized run against a cycle-level model.
module tb_exposure_timer_ctrl;

    localparam int TD = 4;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Exp_increase = 1'b0;
    logic       Exp_decrease = 1'b0;
    logic       Start = 1'b0;
    logic [4:0] Exp_value;
    logic       Expose, Busy, Done;

    always #5 Clk = ~Clk;

    exposure_timer_ctrl #(
        .EXP_W       (5),
        .EXP_MIN     (2),
        .EXP_MAX     (30),
        .EXP_DEFAULT (10),
        .TICK_DIV    (TD)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Exp_increase (Exp_increase),
        .Exp_decrease (Exp_decrease),
        .Start        (Start),
        .Exp_value    (Exp_value),
        .Expose       (Expose),
        .Busy         (Busy),
        .Done         (Done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: exposure value, cycles of Expose still to come, Done pending, button history.
    int m_exp  = 10;
    int m_rem  = 0;
    bit m_done = 0;
    bit m_pi   = 0;
    bit m_pd   = 0;

    typedef struct {
        bit r, i, d, s;
        int exp_v;
        bit ex, bu, dn;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit i, input bit d, input bit s);
        bit idle, ri, rd, nd;
        int nr;
        if (r) begin
            m_exp = 10; m_rem = 0; m_done = 0; m_pi = 0; m_pd = 0;
            return;
        end
        idle = (m_rem == 0) && !m_done;
        ri = i && !m_pi;
        rd = d && !m_pd;
        nd = (m_rem == 1);
        if (m_rem > 0)           nr = m_rem - 1;
        else if (idle && s)      nr = m_exp * TD;
        else                     nr = 0;
        if (idle) begin
            if (ri && !rd && m_exp < 30) m_exp++;
            else if (rd && !ri && m_exp > 2) m_exp--;
        end
        m_pi = i; m_pd = d; m_done = nd; m_rem = nr;
    endtask

    task automatic cycle(input bit r, input bit i, input bit d, input bit s);
        Reset = r; Exp_increase = i; Exp_decrease = d; Start = s;
        @(posedge Clk);
        #1;
        model_step(r, i, d, s);
    endtask

    task automatic step(input bit r, input bit i, input bit d, input bit s);
        cycle(r, i, d, s);
        check("model_exp_value", int'(Exp_value), m_exp);
        check("model_expose", int'(Expose), int'(m_rem > 0));
        check("model_busy", int'(Busy), int'(m_rem > 0 || m_done));
        check("model_done", int'(Done), int'(m_done));
    endtask

    task automatic add(input bit r, i, d, s, input int e, input bit ex, bu, dn);
        vec_t v;
        v.r = r; v.i = i; v.d = d; v.s = s; v.exp_v = e; v.ex = ex; v.bu = bu; v.dn = dn;
        vecs.push_back(v);
    endtask

    // Runs up to a bounded number of cycles counting Expose/Busy/Done highs until idle.
    task automatic measure(output int ex_n, output int bu_n, output int dn_n,
                           input bit inject);
        bit seen_busy = 0;
        ex_n = 0; bu_n = 0; dn_n = 0;
        for (int c = 0; c < 200; c++) begin
            if (inject && c == 10) step(0, 1, 0, 1);
            else step(0, 0, 0, 0);
            ex_n += int'(Expose);
            bu_n += int'(Busy);
            dn_n += int'(Done);
            if (Busy) seen_busy = 1;
            if (seen_busy && !Busy) return;
        end
        check("measure_timeout", 1, 0);
    endtask

    initial begin
        int ex_n, bu_n, dn_n;

        // Table: {reset, inc, dec, start} -> {Exp_value, Expose, Busy, Done} after the edge.
        add(1, 0, 0, 0, 10, 0, 0, 0);
        add(1, 0, 0, 0, 10, 0, 0, 0);
        add(0, 0, 0, 0, 10, 0, 0, 0);
        add(0, 1, 0, 0, 11, 0, 0, 0);
        add(0, 1, 0, 0, 11, 0, 0, 0);
        add(0, 0, 0, 0, 11, 0, 0, 0);
        add(0, 1, 1, 0, 11, 0, 0, 0);
        add(0, 0, 0, 0, 11, 0, 0, 0);
        add(0, 0, 1, 0, 10, 0, 0, 0);
        add(0, 0, 0, 0, 10, 0, 0, 0);
        add(0, 1, 0, 1, 11, 1, 1, 0);
        add(0, 0, 0, 0, 11, 1, 1, 0);
        add(0, 1, 0, 0, 11, 1, 1, 0);
        add(1, 0, 0, 0, 10, 0, 0, 0);

        foreach (vecs[k]) begin
            cycle(vecs[k].r, vecs[k].i, vecs[k].d, vecs[k].s);
            check($sformatf("vec%0d_exp_value", k), int'(Exp_value), vecs[k].exp_v);
            check($sformatf("vec%0d_expose", k), int'(Expose), int'(vecs[k].ex));
            check($sformatf("vec%0d_busy", k), int'(Busy), int'(vecs[k].bu));
            check($sformatf("vec%0d_done", k), int'(Done), int'(vecs[k].dn));
        end

        // Full exposure at default value: 40 Expose cycles, then one Done.
        step(1, 0, 0, 0); step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        measure(ex_n, bu_n, dn_n, 0);
        check("expose_width", ex_n + 1, 40);
        check("busy_width", bu_n + 1, 41);
        check("done_count", dn_n, 1);

        // Saturation up and down.
        for (int k = 0; k < 25; k++) begin step(0, 1, 0, 0); step(0, 0, 0, 0); end
        check("sat_max", int'(Exp_value), 30);
        for (int k = 0; k < 40; k++) begin step(0, 0, 1, 0); step(0, 0, 0, 0); end
        check("sat_min", int'(Exp_value), 2);

        // Held button gives one increment; simultaneous edges cancel.
        step(1, 0, 0, 0);
        for (int k = 0; k < 100; k++) step(0, 1, 0, 0);
        check("held_inc", int'(Exp_value), 11);
        step(0, 0, 0, 0);
        step(0, 1, 1, 0);
        check("inc_dec_same", int'(Exp_value), 11);

        // Adjust + second Start during exposure are ignored.
        step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        measure(ex_n, bu_n, dn_n, 1);
        check("busy_expose_width", ex_n + 1, 40);
        check("busy_done_count", dn_n, 1);
        check("busy_exp_value", int'(Exp_value), 10);

        // Reset partway through an exposure at value 12.
        step(1, 0, 0, 0);
        step(0, 1, 0, 0); step(0, 0, 0, 0); step(0, 1, 0, 0); step(0, 0, 0, 0);
        check("preset_12", int'(Exp_value), 12);
        step(0, 0, 0, 1);
        for (int k = 0; k < 14; k++) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        check("rst_expose", int'(Expose), 0);
        check("rst_busy", int'(Busy), 0);
        check("rst_exp_value", int'(Exp_value), 10);
        dn_n = 0;
        for (int k = 0; k < 60; k++) begin
            step(0, 0, 0, 0);
            dn_n += int'(Done);
        end
        check("rst_no_done", dn_n, 0);

        // Randomized run against the model.
        for (int k = 0; k < 4000; k++) begin
            step(($urandom_range(499) == 0),
                 ($urandom_range(3) == 0) ? ~Exp_increase : Exp_increase,
                 ($urandom_range(3) == 0) ? ~Exp_decrease : Exp_decrease,
                 ($urandom_range(19) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
